// File: rtl/writeback_regfile.sv
// Y86 write-back stage: 15-entry x 64-bit register file with E/M write ports,
// destination decode, a RUN/HALT state machine and a retired-instruction
// counter. Register index 0xF means "no register" throughout.
module writeback_regfile #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             instr_valid,
  input  logic [3:0]       icode,
  input  logic [3:0]       rA,
  input  logic [3:0]       rB,
  input  logic             cnd,
  input  logic [63:0]      valE,
  input  logic [63:0]      valM,
  input  logic [3:0]       dbg_addr,
  output logic [63:0]      dbg_data,
  output logic [3:0]       dstE,
  output logic [3:0]       dstM,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [3:0] IC_HALT   = 4'h0;
  localparam logic [3:0] IC_CMOV   = 4'h2;
  localparam logic [3:0] IC_IRMOV  = 4'h3;
  localparam logic [3:0] IC_MRMOV  = 4'h5;
  localparam logic [3:0] IC_OP     = 4'h6;
  localparam logic [3:0] IC_CALL   = 4'h8;
  localparam logic [3:0] IC_RET    = 4'h9;
  localparam logic [3:0] IC_PUSH   = 4'hA;
  localparam logic [3:0] IC_POP    = 4'hB;
  localparam logic [3:0] REG_NONE  = 4'hF;
  localparam logic [3:0] REG_RSP   = 4'h4;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [63:0] regs [15];
  logic        stop_icode;
  logic        accept;
  logic        wr_en;

  // halt (0) and anything above popq are the instructions that stop the machine
  assign stop_icode = (icode == IC_HALT) || (icode > IC_POP);
  assign accept     = (state == RUN) && instr_valid;
  assign wr_en      = accept && !stop_icode;
  assign halted     = (state == HALT);

  // Destination decode for the E and M write ports
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    dstE = REG_NONE;
    dstM = REG_NONE;
    case (icode)
      IC_CMOV:                         dstE = cnd ? rB : REG_NONE;
      IC_IRMOV, IC_OP:                 dstE = rB;
      IC_CALL, IC_RET, IC_PUSH:        dstE = REG_RSP;
      IC_POP: begin
        dstE = REG_RSP;
        dstM = rA;
      end
      IC_MRMOV:                        dstM = rA;
      default: ;
    endcase
  end

  // Next-state logic: RUN drops to HALT on halt/invalid; only reset leaves HALT
  always_comb begin
    state_next = state;
    if ((state == RUN) && instr_valid && stop_icode) state_next = HALT;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  // Register file: M port wins when both ports target the same register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the register file is flop-based, so it can and must take reset values (each holds its own index).
      for (int i = 0; i < 15; i++) regs[i] <= 64'(i);
    end else if (wr_en) begin
      for (int i = 0; i < 15; i++) begin
        if (dstM == 4'(i))      regs[i] <= valM;
        else if (dstE == 4'(i)) regs[i] <= valE;
      end
    end
  end

  // Retired counter: every accepted instruction, including the halting one
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         retired <= '0;
    else if (accept) retired <= retired + CNT_W'(1);
  end

  // Debug read port; index 0xF matches no entry and reads as zero
  always_comb begin
    dbg_data = '0;
    for (int i = 0; i < 15; i++) begin
      if (dbg_addr == 4'(i)) dbg_data = regs[i];
    end
  end

endmodule
